// File: rtl/res48_chunk_sender.sv
// Serialises a 48-bit word MSB-first as 6-bit chunks under a valid/advance
// handshake, accumulating the word's mod-7 residue chunk by chunk.
module res48_chunk_sender #(
    parameter int N_CHUNKS = 8,
    parameter int CHUNK_W  = 6
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Load,
    input  logic [N_CHUNKS*CHUNK_W-1:0]   Word_in,
    input  logic                          Advance,
    output logic [CHUNK_W-1:0]            D_out,
    output logic                          Valid,
    output logic                          Start,
    output logic                          Last,
    output logic                          Busy,
    output logic [2:0]                    Res_out,
    output logic                          Res_valid
);

    localparam int WORD_W = N_CHUNKS * CHUNK_W;
    localparam int CNT_W  = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    // 2^3 == 1 (mod 7): summing 3-bit groups and folding preserves the residue.
    function automatic logic [2:0] mod7_chunk(input logic [CHUNK_W-1:0] c);
        logic [7:0] s;
        logic [2:0] r;
        s = 8'd0;
        for (int g = 0; g < CHUNK_W / 3; g++) begin
            s = s + {5'd0, c[3*g +: 3]};
        end
        for (int f = 0; f < 4; f++) begin
            s = {5'd0, s[2:0]} + {3'd0, s[7:3]};
        end
        if (s[2:0] == 3'd7) begin
            r = 3'd0;
        end else begin
            r = s[2:0];
        end
        return r;
    endfunction

    function automatic logic [2:0] mod7_add(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] t;
        t = {1'b0, a} + {1'b0, b};
        if (t >= 4'd7) begin
            t = t - 4'd7;
        end else begin
            t = t;
        end
        return t[2:0];
    endfunction

    state_t              state_r, state_s;
    logic [WORD_W-1:0]   shift_r, shift_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [2:0]          acc_r, acc_s;
    logic                valid_r, start_r, last_r, busy_r, res_valid_r;
    logic                valid_s, start_s, last_s, busy_s, res_valid_s;

    // Next-state, datapath and next-output decode; flags derive from the next state.
    always_comb begin
        state_s = state_r;
        shift_s = shift_r;
        cnt_s   = cnt_r;
        acc_s   = acc_r;
        case (state_r)
            IDLE: begin
                if (Load) begin
                    shift_s = Word_in;
                    cnt_s   = {CNT_W{1'b0}};
                    acc_s   = 3'd0;
                    state_s = SEND;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (Advance) begin
                    acc_s   = mod7_add(acc_r, mod7_chunk(shift_r[WORD_W-1 -: CHUNK_W]));
                    shift_s = shift_r << CHUNK_W;
                    cnt_s   = cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(N_CHUNKS - 1)) begin
                        state_s = DONE;
                    end else begin
                        state_s = SEND;
                    end
                end else begin
                    state_s = SEND;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        valid_s     = (state_s == SEND);
        start_s     = (state_s == SEND) && (cnt_s == {CNT_W{1'b0}});
        last_s      = (state_s == SEND) && (cnt_s == CNT_W'(N_CHUNKS - 1));
        busy_s      = (state_s != IDLE);
        res_valid_s = (state_s == DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r     <= IDLE;
            shift_r     <= {WORD_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            acc_r       <= 3'd0;
            valid_r     <= 1'b0;
            start_r     <= 1'b0;
            last_r      <= 1'b0;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            shift_r     <= shift_s;
            cnt_r       <= cnt_s;
            acc_r       <= acc_s;
            valid_r     <= valid_s;
            start_r     <= start_s;
            last_r      <= last_s;
            busy_r      <= busy_s;
            res_valid_r <= res_valid_s;
        end
    end

    assign D_out     = shift_r[WORD_W-1 -: CHUNK_W];
    assign Valid     = valid_r;
    assign Start     = start_r;
    assign Last      = last_r;
    assign Busy      = busy_r;
    assign Res_out   = acc_r;
    assign Res_valid = res_valid_r;

endmodule

// File: tb/tb_res48_chunk_sender.sv
// Self-checking bench: chunk order and residue come from slicing the word and
// taking word % 7 directly.
module tb_res48_chunk_sender;

    logic        Clock = 1'b0;
    logic        Reset, Load, Advance;
    logic [47:0] Word_in;
    logic [5:0]  D_out;
    logic        Valid, Start, Last, Busy, Res_valid;
    logic [2:0]  Res_out;

    int checks = 0;
    int errors = 0;

    localparam logic [47:0] WORD_A = 48'hE88FCA302C89;

    res48_chunk_sender #(.N_CHUNKS(8), .CHUNK_W(6)) dut (
        .Clock(Clock), .Reset(Reset), .Load(Load), .Word_in(Word_in),
        .Advance(Advance), .D_out(D_out), .Valid(Valid), .Start(Start),
        .Last(Last), .Busy(Busy), .Res_out(Res_out), .Res_valid(Res_valid)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, 48'(Valid), 48'd0);
        check({tag, "_busy"}, 48'(Busy), 48'd0);
        check({tag, "_start"}, 48'(Start), 48'd0);
        check({tag, "_last"}, 48'(Last), 48'd0);
        check({tag, "_resv"}, 48'(Res_valid), 48'd0);
    endtask

    // mode 0: advance every cycle; 1: pattern 1,0,0 repeating; 2: random.
    task automatic run_word(input logic [47:0] w, input int mode, input bit inject);
        logic [5:0]  exp_q[$];
        logic [47:0] exp_res;
        logic [63:0] rnd;
        int          idx, cyc;
        bit          adv;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(w[47 - 6*i -: 6]);
        exp_res = w % 48'd7;
        Word_in = w;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 400) begin
            check("valid", 48'(Valid), 48'd1);
            check("busy", 48'(Busy), 48'd1);
            check("chunk", 48'(D_out), 48'(exp_q[idx]));
            check("start", 48'(Start), 48'(idx == 0));
            check("last", 48'(Last), 48'(idx == 7));
            check("resv_send", 48'(Res_valid), 48'd0);
            case (mode)
                0:       adv = 1'b1;
                1:       adv = (cyc % 3 == 0);
                default: adv = 1'($urandom_range(0, 1));
            endcase
            Advance = adv;
            if (inject) begin
                rnd = {$urandom(), $urandom()};
                Word_in = rnd[47:0];
                Load = 1'($urandom_range(0, 1));
            end
            tick();
            if (adv) idx++;
            cyc++;
        end
        check("accepts", 48'(idx), 48'd8);
        Advance = 1'b0;
        Load = inject;
        check("done_resv", 48'(Res_valid), 48'd1);
        check("done_res", 48'(Res_out), exp_res);
        check("done_valid", 48'(Valid), 48'd0);
        check("done_start", 48'(Start), 48'd0);
        check("done_last", 48'(Last), 48'd0);
        check("done_busy", 48'(Busy), 48'd1);
        tick();
        Load = 1'b0;
        check_quiet("idle_after");
        check("res_hold", 48'(Res_out), exp_res);
    endtask

    initial begin
        logic [63:0] rnd;
        Reset = 1'b1;
        Load = 1'b0;
        Advance = 1'b0;
        Word_in = 48'd0;
        tick();
        check_quiet("rst");
        check("rst_dout", 48'(D_out), 48'd0);
        check("rst_res", 48'(Res_out), 48'd0);
        tick();
        Reset = 1'b0;
        tick();
        check_quiet("post_rst");

        run_word(WORD_A, 0, 1'b0);
        check("tp2_res", 48'(Res_out), 48'd2);
        run_word(WORD_A, 1, 1'b0);
        check("tp3_res", 48'(Res_out), 48'd2);
        run_word(48'hFFFFFFFFFFFF, 0, 1'b0);
        check("ones_res", 48'(Res_out), 48'd0);
        run_word(48'h000000000001, 2, 1'b0);
        check("one_res", 48'(Res_out), 48'd1);
        run_word(WORD_A, 2, 1'b1);

        // Advance while idle must not consume anything.
        Advance = 1'b1;
        tick();
        tick();
        check_quiet("idle_adv");
        Advance = 1'b0;
        run_word(48'h123456789ABC, 0, 1'b0);

        // Reset mid-send after four accepted chunks.
        Word_in = WORD_A;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        Advance = 1'b1;
        repeat (4) tick();
        check("mid_chunk", 48'(D_out), 48'd12);
        Advance = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_quiet("mid_rst");
        check("mid_rst_dout", 48'(D_out), 48'd0);
        tick();
        check_quiet("mid_rst2");
        run_word(WORD_A, 0, 1'b0);
        check("tp6_res", 48'(Res_out), 48'd2);

        // Reset and Load together: reset wins.
        Reset = 1'b1;
        Load = 1'b1;
        Word_in = WORD_A;
        tick();
        Reset = 1'b0;
        Load = 1'b0;
        check_quiet("rst_load");
        tick();
        check_quiet("rst_load2");

        for (int k = 0; k < 12; k++) begin
            rnd = {$urandom(), $urandom()};
            run_word(rnd[47:0], k % 3, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/res48_chunk_sender.md
Name: res48_chunk_sender

Overview:
Transmit-side counterpart of the 48-bit residue unit. It loads a 48-bit word, serialises it MSB-first as eight 6-bit chunks under a valid/advance handshake, and flags the first and last chunks. While sending, it accumulates the mod-7 residue of the word and reports it as a one-cycle result. Because 2^6 ≡ 1 (mod 7), the word residue equals the sum of the chunk residues mod 7.

Parameters:
- N_CHUNKS, 8, number of chunks per word; word width = N_CHUNKS*CHUNK_W.
- CHUNK_W, 6, chunk width in bits; must be a multiple of 3 so the mod-7 identity holds; other values unsupported.

Ports:
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Load  in  1  request to capture Word_in; honoured only in IDLE.
- Word_in  in  48  word to send; bits [47:42] are sent first.
- Advance  in  1  downstream accepts the presented chunk this cycle.
- D_out  out  6  current chunk.
- Valid  out  1  D_out holds a chunk.
- Start  out  1  high while the first chunk is presented.
- Last  out  1  high while the final chunk is presented.
- Busy  out  1  high from the cycle after an accepted Load through the DONE cycle.
- Res_out  out  3  residue of the word mod 7, range 0..6.
- Res_valid  out  1  one-cycle pulse when Res_out is final.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; the shift register, chunk counter and accumulator clear.
  - All outputs read 0 on the cycle after the Reset edge.
  - Reset overrides every other input.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - Valid=0, Busy=0.
  - Load=1 at an edge: capture Word_in, counter←0, acc←0, go to SEND.
  - Next cycle: Valid=1, D_out=Word_in[47:42], Start=1, Busy=1.
  - Load latency to first chunk: one cycle.
- SEND:
  - Chunk and flags hold stable while Advance=0; there is no timeout.
  - Advance=1 at an edge: acc←(acc + chunk mod 7) mod 7, shift left by CHUNK_W, counter++.
  - Start=1 only when counter==0.
  - Last=1 only when counter==N_CHUNKS-1.
  - Advance while Last=1: fold the final chunk into acc and go to DONE.
- DONE (exactly one cycle):
  - Valid=0, Start=0, Last=0, Busy=1, Res_valid=1, Res_out=final acc.
  - Then go to IDLE.
- Res_out holds its value after DONE until the next accepted Load clears it to 0. It is undefined for use whenever Res_valid=0.
- Arithmetic:
  - Chunk mod 7 is computed combinationally on 6 bits (e.g. 63→0, 58→2).
  - acc is 3 bits and never takes the value 7; the modular add wraps 6+x correctly.
- Load while Busy=1 (SEND or DONE): ignored, and Word_in is not sampled. No back-to-back overlap: the earliest new Load takes effect in the IDLE cycle after DONE.
- Advance while Valid=0: ignored.
- Reset mid-SEND or in DONE: abort, no Res_valid pulse, remaining chunks discarded.
- Simultaneous Reset and Load: Reset wins.

Test Plan:
1. Reset held 2 cycles, then released -> all outputs 0, Busy=0, Load accepted next.
2. Load Word_in=48'hE88FCA302C89, Advance=1 every cycle:
   - D_out sequence 58, 8, 63, 10, 12, 2, 50, 9.
   - Start=1 on 58 only, Last=1 on 9 only.
   - Next cycle Res_valid=1, Res_out=2.
3. Same word with Advance toggling 1,0,0,1,…:
   - Each chunk and its flags stay stable while Advance=0.
   - Total 8 accepts, Res_out=2.
4. Word 48'hFFFFFFFFFFFF -> eight chunks of 63, Res_out=0.
   Word 48'h000000000001 -> seven 0s then 1, Res_out=1.
5. Assert Load with a different Word_in during SEND -> ignored; the original chunk stream and residue complete unchanged.
6. Reset after 4 chunks accepted -> next cycle Valid=0, Busy=0, no Res_valid. A following Load of 48'hE88FCA302C89 yields Res_out=2.
